psram_async_sequencer: RTL



---
 rtl/psram_async_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/psram_async_sequencer.sv
// Asynchronous-mode PSRAM access sequencer: turns single-word valid/ready requests
// into registered CE/OE/WE/data-drive strobes with programmable wait and recovery time.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | strobes inactive, ready for a request
// S_SETUP   | CE low, address/data settle, data drive on for writes
// S_ACCESS  | OE (read) or WE (write) low for WAIT_CYCLES clocks
// S_HOLD    | OE/WE released, CE still low, completion pulse
// S_RECOVER | CE high for RECOVER_CYCLES clocks before the next access
module psram_async_sequencer #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 16,
  parameter int WAIT_CYCLES    = 4,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_doe,
  input  logic [DATA_W-1:0] mem_din,
  output logic              ram_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ce_n_q, oe_n_q, we_n_q, doe_q, rsp_q, rdy_q;
  logic              active_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SETUP;
          we_d    = req_we;
          adr_d   = req_addr;
          dout_d  = req_wdata;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_HOLD;
          if (!we_q) rdata_d = mem_din;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        cnt_d   = '0;
        state_d = (RECOVER_CYCLES == 0) ? S_IDLE : S_RECOVER;
      end
      S_RECOVER: begin
        if (cnt_q == REC_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin strobes are decoded from the next state so every output leaves a flop.
  assign active_d = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      rsp_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      ce_n_q  <= !active_d;
      oe_n_q  <= !((state_d == S_ACCESS) && !we_d);
      we_n_q  <= !((state_d == S_ACCESS) && we_d);
      doe_q   <= active_d && we_d;
      rsp_q   <= (state_d == S_HOLD);
      rdy_q   <= (state_d == S_IDLE);
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign mem_adr   = adr_q;
  assign mem_dout  = dout_q;
  assign mem_doe   = doe_q;
  assign ram_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;

endmodule
